ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request port, registered read response, nibble-lane write masking and a self-clearing init sequencer. It replaces the tri-state, enable-gated RAM with a fully synchronous block that the CPU datapath and loader drive over a handshake. Contents are zeroed automatically after reset and on demand.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_array.sv | 27 ++
 rtl/ram_ctrl.sv | 90 +++++++++
 tb/tb_ram_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the ram_ctrl block.
package ram_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    localparam int DEFAULT_LANE_W = 4;

    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: single-port storage with per-lane write enables and a registered read.
module ram_array #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int LW = DATA_W / LANES;

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on a read, so it holds the last word between reads
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (we[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: handshake front end, self-clearing init sequencer and response path
// around ram_array.
module ram_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int LANE_W = ram_pkg::DEFAULT_LANE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/LANE_W-1:0] req_mask,
    input  logic                     clear,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     init_busy
);

    import ram_pkg::*;

    localparam int LANES = lane_count(DATA_W, LANE_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              rd_acc;
    logic              in_range;
    logic              sel;
    logic [LANES-1:0]  mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign init_busy = state == INIT;
    assign req_ready = state == RUN && !clear;
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign in_range  = 32'(req_addr) < DEPTH;

    // the init sequencer owns the array port while INIT is active
    assign mem_we    = init_busy ? '1 : (accept && req_we && in_range) ? req_mask : '0;
    assign mem_addr  = init_busy ? cnt : req_addr;
    assign mem_wdata = init_busy ? '0 : req_wdata;

    // sel remembers whether the last read was in range, so the held value
    // is the array word or zero after an out-of-range read
    assign rsp_rdata = sel ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            sel       <= 1'b0;
        end else begin
            rsp_valid <= rd_acc;
            rsp_err   <= rd_acc && !in_range;
            if (rd_acc) sel <= in_range;
            if (clear) begin
                state <= INIT;
                cnt   <= '0;
            end else if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) state <= RUN;
            end
        end
    end

    ram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .re   (rd_acc && in_range),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed scoreboard bench for ram_ctrl (DATA_W=8, DEPTH=12, ADDR_W=4).
module tb_ram_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int LANE_W = 4;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        int                c;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_mask;
    logic              clear;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_busy;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n;
    exp_t q[$];

    ram_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .LANE_W(LANE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_mask (req_mask),
        .clear    (clear),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive one request at a negedge; reads push their expected response
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [1:0] mask,
                         input logic [DATA_W-1:0] exp_d, input logic exp_e);
        exp_t x;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        #1;
        chk("req_ready", 32'(req_ready), 32'd1);
        if (req_ready && !we) begin
            x.d = exp_d;
            x.e = exp_e;
            x.c = cyc + 1;
            q.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] m);
        issue(1'b1, a, d, m, '0, 1'b0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic e);
        issue(1'b0, a, '0, '0, d, e);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (init_busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_init_busy"}, 32'(init_busy), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data %0h err %0b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                exp_t x;
                x = q.pop_front();
                if (rsp_rdata !== x.d || rsp_err !== x.e || cyc != x.c) begin
                    errors++;
                    $display("FAIL rsp: got data %0h err %0b cycle %0d expected data %0h err %0b cycle %0d",
                             rsp_rdata, rsp_err, cyc, x.d, x.e, x.c);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_mask = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        wait_init(n);
        chk("init_len", 32'(n), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) rd(ADDR_W'(a), 8'h00, 1'b0);
        rd(4'd13, 8'h00, 1'b1);
        wr(4'd2, 8'h02, 2'b01);
        rd(4'd2, 8'h02, 1'b0);
        wr(4'd5, 8'hAB, 2'b11);
        wr(4'd5, 8'hCD, 2'b01);
        rd(4'd5, 8'hAD, 1'b0);
        wr(4'd13, 8'hFF, 2'b11);
        rd(4'd13, 8'h00, 1'b1);
        rd(4'd11, 8'h00, 1'b0);
        wr(4'd3, 8'h07, 2'b11);
        rd(4'd3, 8'h07, 1'b0);
        // clear right behind an accepted read: response still arrives, no accept
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; clear = 1'b1;
        #1;
        chk("ready_during_clear", 32'(req_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0; req_valid = 1'b0;
        wait_init(n);
        chk("clear_init_len", 32'(n), 32'(DEPTH));
        rd(4'd3, 8'h00, 1'b0);
        rd(4'd5, 8'h00, 1'b0);
        wr(4'd5, 8'hAB, 2'b11);
        rd(4'd5, 8'hAB, 1'b0);
        idle();
        chk("rdata_hold", 32'(rsp_rdata), 32'hAB);
        // reset in the middle of an init pass
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_mid_init", 32'(init_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_init_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_len", 32'(n), 32'(DEPTH));
        // clear during INIT restarts the counter
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_init(n);
        chk("clear_in_init_len", 32'(n), 32'(DEPTH));
        rd(4'd5, 8'h00, 1'b0);
        idle();
        idle();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
